// File: rtl/lsu_pkg.sv
// =====================================================================
// lsu_pkg: shared size encodings, FSM states and helpers for the LSU.
// Revision 1.0
// =====================================================================
`default_nettype none

package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Number of byte-offset bits inside one data word.
  function automatic int off_width(input int xlen);
    return $clog2(xlen / 8);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// =====================================================================
// lsu_align: alignment check, byte enables, store replication, load extend.
// Revision 1.0
// =====================================================================
`default_nettype none

module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = off_width(XLEN),
  parameter int BE_W  = XLEN / 8
) (
  input  logic [2:0]       req_low,
  input  logic [1:0]       req_size,
  input  logic [XLEN-1:0]  req_wdata,
  output logic             req_ok,
  output logic [BE_W-1:0]  req_be,
  output logic [XLEN-1:0]  req_wdata_rep,
  input  logic [OFF_W-1:0] ld_off,
  input  logic [1:0]       ld_size,
  input  logic             ld_unsigned,
  input  logic [XLEN-1:0]  rdata,
  output logic [XLEN-1:0]  ld_data
);

  logic [BE_W-1:0]  be_base;
  logic [XLEN-1:0]  ld_shift;
  logic [XLEN-1:0]  ld_mask;
  logic             ld_sign;

  always_comb begin
    req_ok        = 1'b0;
    be_base       = '0;
    req_wdata_rep = req_wdata;
    case (req_size)
      SZ_B: begin
        req_ok        = 1'b1;
        be_base       = BE_W'(8'h01);
        req_wdata_rep = {BE_W{req_wdata[7:0]}};
      end
      SZ_H: begin
        req_ok        = ~req_low[0];
        be_base       = BE_W'(8'h03);
        req_wdata_rep = {(XLEN/16){req_wdata[15:0]}};
      end
      SZ_W: begin
        req_ok        = (req_low[1:0] == 2'b00);
        be_base       = BE_W'(8'h0F);
        req_wdata_rep = {(XLEN/32){req_wdata[31:0]}};
      end
      default: begin
        // Double is only meaningful on a 64-bit data path.
        req_ok        = (XLEN == 64) && (req_low == 3'b000);
        be_base       = BE_W'(8'hFF);
        req_wdata_rep = req_wdata;
      end
    endcase
    req_be = be_base << req_low[OFF_W-1:0];
  end

  // Masking the field and filling the upper bits covers every size uniformly;
  // a full-width field leaves nothing to fill, so the unsigned flag drops out.
  always_comb begin
    ld_shift = rdata >> {ld_off, 3'b000};
    ld_mask  = '1;
    ld_sign  = 1'b0;
    case (ld_size)
      SZ_B: begin
        ld_mask = XLEN'(8'hFF);
        ld_sign = ld_shift[7];
      end
      SZ_H: begin
        ld_mask = XLEN'(16'hFFFF);
        ld_sign = ld_shift[15];
      end
      SZ_W: begin
        ld_mask = XLEN'(32'hFFFF_FFFF);
        ld_sign = ld_shift[31];
      end
      default: begin
        ld_mask = '1;
        ld_sign = 1'b0;
      end
    endcase
    ld_data = (ld_shift & ld_mask) | ((ld_sign && !ld_unsigned) ? ~ld_mask : '0);
  end

endmodule

`default_nettype wire

// File: rtl/lsu.sv
// =====================================================================
// lsu: load/store unit between execute and a req/ack data-memory bus.
// Revision 1.0
// =====================================================================
`default_nettype none

module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [1:0]          req_size_i,
  input  logic                req_unsigned_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [XLEN-1:0]     req_wdata_i,
  input  logic [4:0]          req_rd_i,
  output logic                stall_o,
  output logic                resp_valid_o,
  output logic                resp_err_o,
  output logic                wb_wen_o,
  output logic [4:0]          wb_rd_o,
  output logic [XLEN-1:0]     wb_data_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [XLEN/8-1:0]   mem_be_o,
  output logic [XLEN-1:0]     mem_wdata_o,
  input  logic                mem_ack_i,
  input  logic [XLEN-1:0]     mem_rdata_i
);

  localparam int OFF_W = off_width(XLEN);
  localparam int BE_W  = XLEN / 8;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               we_q;
  logic               uns_q;
  logic [1:0]         size_q;
  logic [OFF_W-1:0]   off_q;
  logic [4:0]         rd_q;

  logic               req_ok;
  logic [BE_W-1:0]    req_be;
  logic [XLEN-1:0]    req_wdata_rep;
  logic [XLEN-1:0]    ld_data;

  lsu_align #(
    .XLEN (XLEN)
  ) u_align (
    .req_low       (req_addr_i[2:0]),
    .req_size      (req_size_i),
    .req_wdata     (req_wdata_i),
    .req_ok        (req_ok),
    .req_be        (req_be),
    .req_wdata_rep (req_wdata_rep),
    .ld_off        (off_q),
    .ld_size       (size_q),
    .ld_unsigned   (uns_q),
    .rdata         (mem_rdata_i),
    .ld_data       (ld_data)
  );

  // Gated by rst so every output reads 0 while reset is asserted.
  assign req_ready_o = rst && (state == ST_IDLE);
  assign stall_o     = rst && (((state == ST_IDLE) && req_valid_i) || (state == ST_BUSY));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      size_q       <= '0;
      off_q        <= '0;
      rd_q         <= '0;
      resp_valid_o <= 1'b0;
      resp_err_o   <= 1'b0;
      wb_wen_o     <= 1'b0;
      wb_rd_o      <= '0;
      wb_data_o    <= '0;
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_be_o     <= '0;
      mem_wdata_o  <= '0;
    end else begin
      resp_valid_o <= 1'b0;
      resp_err_o   <= 1'b0;
      wb_wen_o     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid_i) begin
            we_q   <= req_we_i;
            uns_q  <= req_unsigned_i;
            size_q <= req_size_i;
            off_q  <= req_addr_i[OFF_W-1:0];
            rd_q   <= req_rd_i;
            if (req_ok) begin
              state       <= ST_BUSY;
              cnt         <= '0;
              mem_req_o   <= 1'b1;
              mem_we_o    <= req_we_i;
              mem_addr_o  <= {req_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              mem_be_o    <= req_be;
              mem_wdata_o <= req_wdata_rep;
            end else begin
              state        <= ST_RESP;
              resp_valid_o <= 1'b1;
              resp_err_o   <= 1'b1;
              wb_rd_o      <= req_rd_i;
              wb_data_o    <= '0;
            end
          end
        end
        ST_BUSY: begin
          // Ack is tested first so it wins over a coincident timeout.
          if (mem_ack_i) begin
            state        <= ST_RESP;
            resp_valid_o <= 1'b1;
            wb_wen_o     <= !we_q;
            wb_rd_o      <= rd_q;
            wb_data_o    <= we_q ? '0 : ld_data;
            mem_req_o    <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_be_o     <= '0;
          end else if (cnt == CNT_LAST) begin
            state        <= ST_RESP;
            resp_valid_o <= 1'b1;
            resp_err_o   <= 1'b1;
            wb_rd_o      <= rd_q;
            wb_data_o    <= '0;
            mem_req_o    <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_be_o     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lsu.sv
// =====================================================================
// tb_lsu: randomized and directed self-checking bench for lsu.
// Revision 1.0
// =====================================================================
`default_nettype none

module tb_lsu;

  localparam int XLEN    = 32;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 4;

  logic        clk;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [4:0]  req_rd_i;
  logic        stall_o;
  logic        resp_valid_o;
  logic        resp_err_o;
  logic        wb_wen_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  lsu #(.XLEN(XLEN), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_rd_i(req_rd_i), .stall_o(stall_o),
    .resp_valid_o(resp_valid_o), .resp_err_o(resp_err_o), .wb_wen_o(wb_wen_o),
    .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit stray_en = 1'b0;

  // Observations captured by run_op, cycle counts relative to acceptance.
  int          obs_lat, obs_stall, obs_req;
  logic        obs_err, obs_wen, obs_we, obs_unstable, obs_pulse2, obs_ready_after;
  logic [4:0]  obs_rd;
  logic [31:0] obs_data, obs_addr, obs_wd;
  logic [3:0]  obs_be;

  // Reference: bytes are picked and placed one at a time from the rules.
  function automatic void model(input logic we, input logic [1:0] sz, input logic uns,
                                input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                                input int k, output int lat, output int nreq, output logic err,
                                output logic wen, output logic [31:0] data, output logic [3:0] be,
                                output logic [31:0] maddr, output logic [31:0] wrep);
    int nb, off;
    nb = 1 << sz;
    off = int'(a[1:0]);
    be = '0;
    for (int i = 0; i < nb && off + i < 4; i++) be[off+i] = 1'b1;
    maddr = {a[31:2], 2'b00};
    for (int b = 0; b < 4; b++) wrep[8*b +: 8] = wd[8*(b % nb) +: 8];
    data = '0;
    for (int i = 0; i < nb && off + i < 4; i++) data[8*i +: 8] = rdat[8*(off+i) +: 8];
    if (!uns && nb < 4 && data[8*nb-1])
      for (int i = nb; i < 4; i++) data[8*i +: 8] = 8'hFF;
    if (sz == 2'b11 || (int'(a[2:0]) % nb) != 0) begin
      lat = 1; nreq = 0; err = 1'b1; wen = 1'b0;
    end else if (k < 0 || k >= TIMEOUT) begin
      lat = TIMEOUT + 1; nreq = TIMEOUT; err = 1'b1; wen = 1'b0;
    end else begin
      lat = k + 2; nreq = k + 1; err = 1'b0; wen = !we;
    end
  endfunction

  // Issues one request and plays the memory; k<0 means the bus never acks.
  task automatic run_op(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                        input int k, input logic [31:0] rdat);
    int reqs;
    bit done;
    obs_lat = -1; obs_stall = 0; obs_err = 1'bx; obs_wen = 1'bx; obs_rd = 'x; obs_data = 'x;
    obs_addr = 'x; obs_be = 'x; obs_wd = 'x; obs_we = 1'bx; obs_unstable = 1'b0;
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = we; req_size_i = sz; req_unsigned_i = uns;
    req_addr_i = a; req_wdata_i = wd; req_rd_i = rd;
    mem_ack_i = stray_en; mem_rdata_i = $urandom;
    #1;
    if (stall_o) obs_stall++;
    reqs = 0;
    done = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge clk);
      if (stall_o) obs_stall++;
      if (mem_req_o) begin
        reqs++;
        if (reqs == 1) begin
          obs_addr = mem_addr_o; obs_be = mem_be_o; obs_wd = mem_wdata_o; obs_we = mem_we_o;
        end else if (obs_addr !== mem_addr_o || obs_be !== mem_be_o ||
                     obs_wd !== mem_wdata_o || obs_we !== mem_we_o) begin
          obs_unstable = 1'b1;
        end
      end
      if (resp_valid_o) begin
        obs_lat = c; obs_err = resp_err_o; obs_wen = wb_wen_o; obs_rd = wb_rd_o; obs_data = wb_data_o;
        done = 1'b1;
      end
      if (mem_req_o && k >= 0 && reqs - 1 == k) begin
        mem_ack_i = 1'b1; mem_rdata_i = rdat;
      end else begin
        mem_ack_i = (stray_en && !mem_req_o) ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_rdata_i = $urandom;
      end
    end
    obs_req = reqs;
    @(negedge clk);
    obs_pulse2 = resp_valid_o;
    obs_ready_after = req_ready_o;
    req_valid_i = 1'b0;
    mem_ack_i = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({req_ready_o, stall_o, resp_valid_o, resp_err_o, wb_wen_o, mem_req_o, mem_we_o} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 0000000",
               {req_ready_o, stall_o, resp_valid_o, resp_err_o, wb_wen_o, mem_req_o, mem_we_o});
    end
    n_cmp++;
    if ({wb_rd_o, wb_data_o, mem_addr_o, mem_be_o, mem_wdata_o} !== '0) begin
      n_err++;
      $display("FAIL reset_buses: got rd=%h data=%h addr=%h be=%b wd=%h want all 0",
               wb_rd_o, wb_data_o, mem_addr_o, mem_be_o, mem_wdata_o);
    end
    req_valid_i = 1'b1;
    #1;
    n_cmp++;
    if (stall_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_stall: got %b want 0", stall_o);
    end
    req_valid_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL idle_ready: got %b want 1", req_ready_o);
    end
  endtask

  task automatic test_lb_sign;
    run_op(1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0, 5'd7, 0, 32'h80FF_1234);
    n_cmp++;
    if (obs_be !== 4'b1000 || obs_addr !== 32'h0000_1000) begin
      n_err++;
      $display("FAIL lb_bus: got be=%b addr=%h want be=1000 addr=00001000", obs_be, obs_addr);
    end
    n_cmp++;
    if (obs_data !== 32'hFFFF_FF80 || obs_wen !== 1'b1 || obs_rd !== 5'd7) begin
      n_err++;
      $display("FAIL lb_wb: got data=%h wen=%b rd=%0d want ffffff80 1 7", obs_data, obs_wen, obs_rd);
    end
    n_cmp++;
    if (obs_lat != 2 || obs_stall != 2) begin
      n_err++;
      $display("FAIL lb_timing: got lat=%0d stall=%0d want 2 2", obs_lat, obs_stall);
    end
  endtask

  task automatic test_lhu_wait;
    run_op(1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0, 5'd9, 3, 32'hBEEF_0000);
    n_cmp++;
    if (obs_data !== 32'h0000_BEEF || obs_wen !== 1'b1) begin
      n_err++;
      $display("FAIL lhu_wb: got data=%h wen=%b want 0000beef 1", obs_data, obs_wen);
    end
    n_cmp++;
    if (obs_lat != 5 || obs_stall != 5 || obs_req != 4) begin
      n_err++;
      $display("FAIL lhu_timing: got lat=%0d stall=%0d req=%0d want 5 5 4", obs_lat, obs_stall, obs_req);
    end
  endtask

  task automatic test_sb;
    run_op(1'b1, 2'b00, 1'b0, 32'h0000_0001, 32'h1234_56A5, 5'd3, 0, 32'h5555_5555);
    n_cmp++;
    if (obs_be !== 4'b0010 || obs_wd !== 32'hA5A5_A5A5 || obs_we !== 1'b1) begin
      n_err++;
      $display("FAIL sb_bus: got be=%b wd=%h we=%b want 0010 a5a5a5a5 1", obs_be, obs_wd, obs_we);
    end
    n_cmp++;
    if (obs_lat != 2 || obs_wen !== 1'b0 || obs_err !== 1'b0) begin
      n_err++;
      $display("FAIL sb_resp: got lat=%0d wen=%b err=%b want 2 0 0", obs_lat, obs_wen, obs_err);
    end
  endtask

  task automatic test_misaligned;
    run_op(1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0, 5'd1, 0, 32'h0);
    n_cmp++;
    if (obs_req != 0 || obs_lat != 1 || obs_stall != 1) begin
      n_err++;
      $display("FAIL mis_timing: got req=%0d lat=%0d stall=%0d want 0 1 1", obs_req, obs_lat, obs_stall);
    end
    n_cmp++;
    if (obs_err !== 1'b1 || obs_wen !== 1'b0) begin
      n_err++;
      $display("FAIL mis_resp: got err=%b wen=%b want 1 0", obs_err, obs_wen);
    end
  endtask

  task automatic test_timeout;
    run_op(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 5'd4, -1, 32'h0);
    n_cmp++;
    if (obs_req != TIMEOUT || obs_lat != TIMEOUT + 1 || obs_err !== 1'b1 || obs_wen !== 1'b0) begin
      n_err++;
      $display("FAIL timeout: got req=%0d lat=%0d err=%b wen=%b want %0d %0d 1 0",
               obs_req, obs_lat, obs_err, obs_wen, TIMEOUT, TIMEOUT + 1);
    end
    run_op(1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0, 5'd5, TIMEOUT - 1, 32'hCAFE_0001);
    n_cmp++;
    if (obs_lat != TIMEOUT + 1 || obs_err !== 1'b0 || obs_wen !== 1'b1 || obs_data !== 32'hCAFE_0001) begin
      n_err++;
      $display("FAIL ack_last: got lat=%0d err=%b wen=%b data=%h want %0d 0 1 cafe0001",
               obs_lat, obs_err, obs_wen, obs_data, TIMEOUT + 1);
    end
  endtask

  task automatic test_reset_busy;
    int seen;
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'b10; req_unsigned_i = 1'b0;
    req_addr_i = 32'h40; req_wdata_i = 32'h0; req_rd_i = 5'd2; mem_ack_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (mem_req_o !== 1'b1) begin
      n_err++;
      $display("FAIL rstbusy_req: got %b want 1", mem_req_o);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (mem_req_o !== 1'b0 || stall_o !== 1'b0) begin
      n_err++;
      $display("FAIL rstbusy_drop: got req=%b stall=%b want 0 0", mem_req_o, stall_o);
    end
    req_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid_o) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL rstbusy_noresp: got %0d pulses want 0", seen);
    end
    run_op(1'b0, 2'b10, 1'b0, 32'h0000_0044, 32'h0, 5'd12, 1, 32'h1234_5678);
    n_cmp++;
    if (obs_lat != 3 || obs_wen !== 1'b1 || obs_data !== 32'h1234_5678 || obs_err !== 1'b0) begin
      n_err++;
      $display("FAIL rstbusy_after: got lat=%0d wen=%b data=%h err=%b want 3 1 12345678 0",
               obs_lat, obs_wen, obs_data, obs_err);
    end
  endtask

  task automatic test_random;
    stray_en = 1'b1;
    for (int n = 0; n < 60; n++) begin
      logic        we_r, uns_r, e_err, e_wen;
      logic [1:0]  sz;
      logic [31:0] a, wd, rdat, e_data, e_addr, e_wd;
      logic [3:0]  e_be;
      logic [4:0]  rdn;
      int          k, nb, e_lat, e_req;
      we_r = 1'($urandom_range(0, 1));
      uns_r = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a = $urandom; wd = $urandom; rdat = $urandom;
      rdn = 5'($urandom_range(0, 31));
      nb = 1 << sz;
      if ($urandom_range(0, 3) != 0) a = a & ~(32'(nb) - 32'd1);
      k = int'($urandom_range(0, 5));
      if (k == 5) k = -1;
      model(we_r, sz, uns_r, a, wd, rdat, k, e_lat, e_req, e_err, e_wen, e_data, e_be, e_addr, e_wd);
      run_op(we_r, sz, uns_r, a, wd, rdn, k, rdat);
      n_cmp++;
      if (obs_lat != e_lat || obs_stall != e_lat || obs_req != e_req) begin
        n_err++;
        $display("FAIL rnd%0d timing: got lat=%0d stall=%0d req=%0d want %0d %0d %0d",
                 n, obs_lat, obs_stall, obs_req, e_lat, e_lat, e_req);
      end
      n_cmp++;
      if (obs_err !== e_err || obs_wen !== e_wen) begin
        n_err++;
        $display("FAIL rnd%0d resp: got err=%b wen=%b want %b %b", n, obs_err, obs_wen, e_err, e_wen);
      end
      if (e_wen) begin
        n_cmp++;
        if (obs_data !== e_data || obs_rd !== rdn) begin
          n_err++;
          $display("FAIL rnd%0d load: got data=%h rd=%0d want %h %0d", n, obs_data, obs_rd, e_data, rdn);
        end
      end
      if (e_req > 0) begin
        n_cmp++;
        if (obs_addr !== e_addr || obs_be !== e_be || obs_we !== we_r || obs_unstable !== 1'b0 ||
            (we_r && obs_wd !== e_wd)) begin
          n_err++;
          $display("FAIL rnd%0d bus: got addr=%h be=%b we=%b wd=%h unstable=%b want %h %b %b %h 0",
                   n, obs_addr, obs_be, obs_we, obs_wd, obs_unstable, e_addr, e_be, we_r, e_wd);
        end
      end
      n_cmp++;
      if (obs_pulse2 !== 1'b0 || obs_ready_after !== 1'b1) begin
        n_err++;
        $display("FAIL rnd%0d after_resp: got valid=%b ready=%b want 0 1", n, obs_pulse2, obs_ready_after);
      end
    end
    stray_en = 1'b0;
  endtask

  initial begin
    rst = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'b00; req_unsigned_i = 1'b0;
    req_addr_i = '0; req_wdata_i = '0; req_rd_i = '0; mem_ack_i = 1'b0; mem_rdata_i = '0;
    test_reset();
    test_lb_sign();
    test_lhu_wait();
    test_sb();
    test_misaligned();
    test_timeout();
    test_reset_busy();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
